// File: rtl/tdp18k_preload_ctl.sv
// tdp18k_preload_ctl
//   Command-driven controller for the TDP18K block-RAM preload chain.
//   It turns write-burst, read-burst and BIST commands into preload bus
//   strobes, returns read data, and checks BIST read-back against a pattern.
//
// Ports
//   PL_CLK_i, PL_RESET_i         clock, synchronous active-high reset
//   CMD_*                        command handshake: op, target ID, start word,
//                                length-1, BIST pattern
//   WDATA_*                      write-data stream (used by write bursts)
//   RDATA_VALID_o / RDATA_o      read-data stream, no backpressure
//   PL_ENA/WEN/REN/INIT_o        registered preload bus strobes
//   PL_ADDR_o / PL_DATA_o        bus address {row, col, 2'b0, word} and data
//   PL_DATA_IN_i                 chain data, valid READ_LAT cycles after REN
//   BUSY_o, DONE_o, BIST_FAIL_o, ERR_o   status
module tdp18k_preload_ctl #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 10
) (
  input  logic        PL_CLK_i,
  input  logic        PL_RESET_i,
  input  logic        CMD_VALID_i,
  output logic        CMD_READY_o,
  input  logic [1:0]  CMD_OP_i,
  input  logic [19:0] CMD_ID_i,
  input  logic [9:0]  CMD_ADDR_i,
  input  logic [9:0]  CMD_LEN_i,
  input  logic [17:0] CMD_PAT_i,
  input  logic        WDATA_VALID_i,
  output logic        WDATA_READY_o,
  input  logic [17:0] WDATA_i,
  output logic        RDATA_VALID_o,
  output logic [17:0] RDATA_o,
  output logic        PL_ENA_o,
  output logic        PL_WEN_o,
  output logic        PL_REN_o,
  output logic        PL_INIT_o,
  output logic [31:0] PL_ADDR_o,
  output logic [17:0] PL_DATA_o,
  input  logic [17:0] PL_DATA_IN_i,
  output logic        BUSY_o,
  output logic        DONE_o,
  output logic        BIST_FAIL_o,
  output logic        ERR_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WR    = 3'd1;
  localparam logic [2:0] RD    = 3'd2;
  localparam logic [2:0] BW    = 3'd3;
  localparam logic [2:0] BR    = 3'd4;
  localparam logic [2:0] DRAIN = 3'd5;
  localparam logic [2:0] FIN   = 3'd6;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_BIST = 2'b10;

  logic [2:0]        state;
  logic [19:0]       id_q;
  logic [ADDR_W-1:0] addr_q, start_q, len_q, cnt_q;
  logic [17:0]       pat_q;
  logic [9:0]        word;

  // vld_pipe tracks user reads (go to RDATA), chk_pipe tracks BIST reads
  // (compared, never exposed). Bit 0 is set together with PL_REN_o, so bit
  // READ_LAT lines up with the cycle PL_DATA_IN_i is valid.
  logic [READ_LAT:0] vld_pipe, chk_pipe;
  logic              in_flight;

  assign word      = 10'(addr_q);
  assign in_flight = (|vld_pipe[READ_LAT-1:0]) | (|chk_pipe[READ_LAT-1:0]);

  assign CMD_READY_o   = (state == IDLE);
  assign BUSY_o        = (state != IDLE);
  assign WDATA_READY_o = (state == WR);
  assign DONE_o        = (state == FIN);
  assign RDATA_VALID_o = vld_pipe[READ_LAT];
  assign RDATA_o       = vld_pipe[READ_LAT] ? PL_DATA_IN_i : 18'd0;

  always_ff @(posedge PL_CLK_i) begin
    if (PL_RESET_i) begin
      state       <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      start_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      pat_q       <= '0;
      PL_ENA_o    <= 1'b0;
      PL_WEN_o    <= 1'b0;
      PL_REN_o    <= 1'b0;
      PL_INIT_o   <= 1'b0;
      PL_ADDR_o   <= '0;
      PL_DATA_o   <= '0;
      vld_pipe    <= '0;
      chk_pipe    <= '0;
      BIST_FAIL_o <= 1'b0;
      ERR_o       <= 1'b0;
    end else begin
      // strobes are single-cycle; address/data hold unless reissued
      PL_ENA_o  <= 1'b0;
      PL_WEN_o  <= 1'b0;
      PL_REN_o  <= 1'b0;
      PL_INIT_o <= 1'b0;
      ERR_o     <= 1'b0;
      vld_pipe  <= {vld_pipe[READ_LAT-1:0], 1'b0};
      chk_pipe  <= {chk_pipe[READ_LAT-1:0], 1'b0};

      if (chk_pipe[READ_LAT] && (PL_DATA_IN_i != pat_q))
        BIST_FAIL_o <= 1'b1;

      case (state)
        IDLE: begin
          if (CMD_VALID_i) begin
            if (CMD_OP_i == 2'b11) begin
              ERR_o <= 1'b1;
            end else begin
              id_q    <= CMD_ID_i;
              addr_q  <= ADDR_W'(CMD_ADDR_i);
              start_q <= ADDR_W'(CMD_ADDR_i);
              len_q   <= ADDR_W'(CMD_LEN_i);
              cnt_q   <= ADDR_W'(CMD_LEN_i);
              pat_q   <= CMD_PAT_i;
              case (CMD_OP_i)
                OP_WR:   state <= WR;
                OP_RD:   state <= RD;
                default: begin
                  state       <= BW;
                  BIST_FAIL_o <= 1'b0;
                end
              endcase
            end
          end
        end

        WR: begin
          if (WDATA_VALID_i) begin
            PL_ENA_o  <= 1'b1;
            PL_WEN_o  <= 1'b1;
            PL_ADDR_o <= {id_q, 2'b00, word};
            PL_DATA_o <= WDATA_i;
            addr_q    <= addr_q + ADDR_W'(1);
            cnt_q     <= cnt_q - ADDR_W'(1);
            if (cnt_q == '0) state <= FIN;
          end
        end

        RD: begin
          PL_ENA_o    <= 1'b1;
          PL_REN_o    <= 1'b1;
          PL_ADDR_o   <= {id_q, 2'b00, word};
          vld_pipe[0] <= 1'b1;
          addr_q      <= addr_q + ADDR_W'(1);
          cnt_q       <= cnt_q - ADDR_W'(1);
          if (cnt_q == '0) state <= DRAIN;
        end

        BW: begin
          PL_ENA_o  <= 1'b1;
          PL_WEN_o  <= 1'b1;
          PL_ADDR_o <= {22'd0, word};
          PL_DATA_o <= pat_q;
          addr_q    <= addr_q + ADDR_W'(1);
          cnt_q     <= cnt_q - ADDR_W'(1);
          if (cnt_q == '0) begin
            // replay the same word range for the read-back pass
            state  <= BR;
            addr_q <= start_q;
            cnt_q  <= len_q;
          end
        end

        BR: begin
          PL_ENA_o    <= 1'b1;
          PL_REN_o    <= 1'b1;
          PL_INIT_o   <= 1'b1;
          PL_ADDR_o   <= {22'd0, word};
          PL_DATA_o   <= pat_q;
          chk_pipe[0] <= 1'b1;
          addr_q      <= addr_q + ADDR_W'(1);
          cnt_q       <= cnt_q - ADDR_W'(1);
          if (cnt_q == '0) state <= DRAIN;
        end

        // the return in stage READ_LAT (if any) is consumed this cycle, so
        // leave once nothing is left behind it
        DRAIN:   if (!in_flight) state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdp18k_preload_ctl.sv
module tb_tdp18k_preload_ctl;

  logic        PL_CLK_i = 1'b0;
  logic        PL_RESET_i;
  logic        CMD_VALID_i, CMD_READY_o;
  logic [1:0]  CMD_OP_i;
  logic [19:0] CMD_ID_i;
  logic [9:0]  CMD_ADDR_i, CMD_LEN_i;
  logic [17:0] CMD_PAT_i;
  logic        WDATA_VALID_i, WDATA_READY_o;
  logic [17:0] WDATA_i;
  logic        RDATA_VALID_o;
  logic [17:0] RDATA_o;
  logic        PL_ENA_o, PL_WEN_o, PL_REN_o, PL_INIT_o;
  logic [31:0] PL_ADDR_o;
  logic [17:0] PL_DATA_o;
  logic [17:0] PL_DATA_IN_i;
  logic        BUSY_o, DONE_o, BIST_FAIL_o, ERR_o;

  int checks = 0;
  int errors = 0;

  // chain model: 0 -> returns word+0x100, 1 -> echoes bus data
  bit model_mode = 1'b0;
  bit flip_en    = 1'b0;

  tdp18k_preload_ctl dut (
    .PL_CLK_i(PL_CLK_i), .PL_RESET_i(PL_RESET_i),
    .CMD_VALID_i(CMD_VALID_i), .CMD_READY_o(CMD_READY_o), .CMD_OP_i(CMD_OP_i),
    .CMD_ID_i(CMD_ID_i), .CMD_ADDR_i(CMD_ADDR_i), .CMD_LEN_i(CMD_LEN_i),
    .CMD_PAT_i(CMD_PAT_i), .WDATA_VALID_i(WDATA_VALID_i),
    .WDATA_READY_o(WDATA_READY_o), .WDATA_i(WDATA_i),
    .RDATA_VALID_o(RDATA_VALID_o), .RDATA_o(RDATA_o),
    .PL_ENA_o(PL_ENA_o), .PL_WEN_o(PL_WEN_o), .PL_REN_o(PL_REN_o),
    .PL_INIT_o(PL_INIT_o), .PL_ADDR_o(PL_ADDR_o), .PL_DATA_o(PL_DATA_o),
    .PL_DATA_IN_i(PL_DATA_IN_i), .BUSY_o(BUSY_o), .DONE_o(DONE_o),
    .BIST_FAIL_o(BIST_FAIL_o), .ERR_o(ERR_o)
  );

  always #5 PL_CLK_i = ~PL_CLK_i;

  // one-cycle read latency chain model
  always @(posedge PL_CLK_i) begin
    if (PL_REN_o) begin
      if (!model_mode)
        PL_DATA_IN_i <= 18'(PL_ADDR_o[9:0]) + 18'h100;
      else if (flip_en && PL_ADDR_o[9:0] == 10'd4)
        PL_DATA_IN_i <= PL_DATA_o ^ 18'h20;
      else
        PL_DATA_IN_i <= PL_DATA_o;
    end
  end

  task automatic tick();
    @(posedge PL_CLK_i);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [19:0] id,
                          input logic [9:0] a, input logic [9:0] l,
                          input logic [17:0] p);
    CMD_OP_i = op; CMD_ID_i = id; CMD_ADDR_i = a; CMD_LEN_i = l; CMD_PAT_i = p;
    CMD_VALID_i = 1'b1;
    tick();
    CMD_VALID_i = 1'b0;
  endtask

  task automatic test_reset();
    PL_RESET_i = 1'b1;
    repeat (3) tick();
    PL_RESET_i = 1'b0;
    checks++;
    if (CMD_READY_o !== 1'b1 || BUSY_o !== 1'b0 || DONE_o !== 1'b0 || ERR_o !== 1'b0 ||
        BIST_FAIL_o !== 1'b0 || RDATA_VALID_o !== 1'b0 || WDATA_READY_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_status rdy=%b busy=%b done=%b err=%b bf=%b rv=%b wr=%b exp 1000000",
               CMD_READY_o, BUSY_o, DONE_o, ERR_o, BIST_FAIL_o, RDATA_VALID_o, WDATA_READY_o);
    end
    checks++;
    if ({PL_ENA_o, PL_WEN_o, PL_REN_o, PL_INIT_o} !== 4'b0 || PL_ADDR_o !== 32'd0 ||
        PL_DATA_o !== 18'd0) begin
      errors++;
      $display("FAIL reset_bus strobes=%b addr=%h data=%h exp 0", {PL_ENA_o, PL_WEN_o,
               PL_REN_o, PL_INIT_o}, PL_ADDR_o, PL_DATA_o);
    end
  endtask

  task automatic test_write();
    logic [17:0] wd [4];
    logic [9:0]  ew [4];
    int wi = 0, nw = 0;
    bit done = 0, hs;
    wd = '{18'h0AAAA, 18'h0BBBB, 18'h0CCCC, 18'h0DDDD};
    ew = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    send_cmd(2'b00, 20'h00401, 10'h3FE, 10'd3, 18'd0);
    checks++;
    if (BUSY_o !== 1'b1 || CMD_READY_o !== 1'b0 || WDATA_READY_o !== 1'b1) begin
      errors++;
      $display("FAIL wr_enter busy=%b rdy=%b wready=%b exp 1 0 1", BUSY_o, CMD_READY_o, WDATA_READY_o);
    end
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      WDATA_VALID_i = WDATA_READY_o && wi < 4 && cyc != 1;
      WDATA_i = (wi < 4) ? wd[wi] : 18'd0;
      hs = WDATA_VALID_i && WDATA_READY_o;
      tick();
      if (hs) wi++;
      if (cyc == 1) begin
        checks++;
        if (PL_WEN_o !== 1'b0 || PL_ADDR_o !== {20'h00401, 2'b00, 10'h3FE}) begin
          errors++;
          $display("FAIL wr_gap wen=%b addr=%h exp 0 004013fe", PL_WEN_o, PL_ADDR_o);
        end
      end
      if (PL_WEN_o) begin
        checks++;
        if (nw >= 4 || PL_ENA_o !== 1'b1 || PL_INIT_o !== 1'b0 ||
            PL_ADDR_o !== {20'h00401, 2'b00, ew[nw]} || PL_DATA_o !== wd[nw]) begin
          errors++;
          $display("FAIL wr_word%0d addr=%h data=%h ena=%b exp addr=%h data=%h", nw,
                   PL_ADDR_o, PL_DATA_o, PL_ENA_o, {20'h00401, 2'b00, ew[nw & 3]}, wd[nw & 3]);
        end
        nw++;
      end
      if (DONE_o) done = 1;
    end
    WDATA_VALID_i = 1'b0;
    checks++;
    if (!done || nw != 4) begin
      errors++;
      $display("FAIL wr_count done=%0d words=%0d exp 1 4", done, nw);
    end
    tick();
    checks++;
    if (DONE_o !== 1'b0 || CMD_READY_o !== 1'b1 || PL_WEN_o !== 1'b0 ||
        PL_ADDR_o !== {20'h00401, 2'b00, 10'h001} || PL_DATA_o !== 18'h0DDDD) begin
      errors++;
      $display("FAIL wr_after done=%b rdy=%b wen=%b addr=%h data=%h exp 0 1 0 00401001 0dddd",
               DONE_o, CMD_READY_o, PL_WEN_o, PL_ADDR_o, PL_DATA_o);
    end
  endtask

  task automatic test_read();
    int nren = 0, nret = 0;
    int ren_cyc [8];
    bit done = 0, err_seen = 0;
    model_mode = 1'b0;
    send_cmd(2'b01, 20'h00C03, 10'd0, 10'd2, 18'd0);
    // a command held while busy must be ignored
    CMD_OP_i = 2'b11; CMD_VALID_i = 1'b1;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      tick();
      if (PL_REN_o) begin
        checks++;
        if (nren >= 8 || PL_ENA_o !== 1'b1 || PL_INIT_o !== 1'b0 ||
            PL_ADDR_o !== {20'h00C03, 2'b00, 10'(nren)}) begin
          errors++;
          $display("FAIL rd_issue%0d addr=%h ena=%b init=%b exp addr=%h", nren, PL_ADDR_o,
                   PL_ENA_o, PL_INIT_o, {20'h00C03, 2'b00, 10'(nren)});
        end
        if (nren < 8) ren_cyc[nren] = cyc;
        nren++;
      end
      if (RDATA_VALID_o) begin
        checks++;
        if (nret >= nren || nret >= 8 || RDATA_o !== 18'h100 + 18'(nret) ||
            cyc != ren_cyc[nret] + 1) begin
          errors++;
          $display("FAIL rd_data%0d got=%h at cyc %0d exp %h", nret, RDATA_o, cyc, 18'h100 + 18'(nret));
        end
        nret++;
      end
      if (ERR_o) err_seen = 1;
      if (DONE_o) begin
        done = 1;
        CMD_VALID_i = 1'b0;
      end
    end
    CMD_VALID_i = 1'b0;
    checks++;
    if (!done || nren != 3 || nret != 3 || err_seen || ren_cyc[2] - ren_cyc[0] != 2) begin
      errors++;
      $display("FAIL rd_summary done=%0d ren=%0d ret=%0d err=%0d exp 1 3 3 0", done, nren, nret, err_seen);
    end
    tick();
    checks++;
    if (CMD_READY_o !== 1'b1 || ERR_o !== 1'b0 || DONE_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle rdy=%b err=%b done=%b exp 1 0 0", CMD_READY_o, ERR_o, DONE_o);
    end
  endtask

  task automatic test_illegal();
    send_cmd(2'b11, 20'h00401, 10'd5, 10'd3, 18'd0);
    checks++;
    if (ERR_o !== 1'b1 || CMD_READY_o !== 1'b1 || BUSY_o !== 1'b0) begin
      errors++;
      $display("FAIL ill_pulse err=%b rdy=%b busy=%b exp 1 1 0", ERR_o, CMD_READY_o, BUSY_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ERR_o !== 1'b0 || CMD_READY_o !== 1'b1 ||
          {PL_ENA_o, PL_WEN_o, PL_REN_o, PL_INIT_o} !== 4'b0) begin
        errors++;
        $display("FAIL ill_after%0d err=%b rdy=%b strobes=%b exp 0 1 0000", i, ERR_o,
                 CMD_READY_o, {PL_ENA_o, PL_WEN_o, PL_REN_o, PL_INIT_o});
      end
    end
  endtask

  task automatic test_bist_pass();
    int nw = 0, nr = 0;
    bit done = 0, rv_seen = 0;
    model_mode = 1'b1; flip_en = 1'b0;
    send_cmd(2'b10, 20'h00401, 10'd0, 10'd7, 18'h2AAAA);
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      tick();
      if (PL_WEN_o) begin
        checks++;
        if (PL_INIT_o !== 1'b0 || PL_ADDR_o !== {22'd0, 10'(nw)} || PL_DATA_o !== 18'h2AAAA) begin
          errors++;
          $display("FAIL bw_word%0d addr=%h data=%h init=%b exp %h 2aaaa 0", nw, PL_ADDR_o,
                   PL_DATA_o, PL_INIT_o, {22'd0, 10'(nw)});
        end
        nw++;
      end
      if (PL_REN_o) begin
        checks++;
        if (PL_INIT_o !== 1'b1 || PL_ADDR_o !== {22'd0, 10'(nr)} || PL_DATA_o !== 18'h2AAAA ||
            nw != 8) begin
          errors++;
          $display("FAIL br_word%0d addr=%h data=%h init=%b exp %h 2aaaa 1", nr, PL_ADDR_o,
                   PL_DATA_o, PL_INIT_o, {22'd0, 10'(nr)});
        end
        nr++;
      end
      if (RDATA_VALID_o) rv_seen = 1;
      if (DONE_o) done = 1;
    end
    checks++;
    if (!done || nw != 8 || nr != 8 || rv_seen || BIST_FAIL_o !== 1'b0) begin
      errors++;
      $display("FAIL bist_pass done=%0d wr=%0d rd=%0d rv=%0d fail=%b exp 1 8 8 0 0",
               done, nw, nr, rv_seen, BIST_FAIL_o);
    end
    tick();
  endtask

  task automatic test_bist_fail();
    int rets = 0, bad = 0;
    bit done = 0, prev_ren = 0;
    model_mode = 1'b1; flip_en = 1'b1;
    send_cmd(2'b10, 20'h00000, 10'd0, 10'd7, 18'h2AAAA);
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      tick();
      // flag reflects every return completed before this cycle
      checks++;
      if (BIST_FAIL_o !== (rets >= 5)) begin
        errors++; bad++;
        $display("FAIL bist_flag cyc%0d got=%b exp=%b", cyc, BIST_FAIL_o, rets >= 5);
      end
      if (prev_ren) rets++;
      prev_ren = PL_REN_o;
      if (DONE_o) done = 1;
    end
    checks++;
    if (!done || rets != 8 || BIST_FAIL_o !== 1'b1) begin
      errors++;
      $display("FAIL bist_fail_end done=%0d rets=%0d fail=%b exp 1 8 1", done, rets, BIST_FAIL_o);
    end
    flip_en = 1'b0;
  endtask

  task automatic test_bist_clear();
    bit done = 0;
    repeat (2) tick();
    checks++;
    if (BIST_FAIL_o !== 1'b1) begin
      errors++;
      $display("FAIL bist_sticky got=%b exp 1", BIST_FAIL_o);
    end
    send_cmd(2'b10, 20'h00000, 10'd100, 10'd3, 18'h15555);
    checks++;
    if (BIST_FAIL_o !== 1'b0 || BUSY_o !== 1'b1) begin
      errors++;
      $display("FAIL bist_clear fail=%b busy=%b exp 0 1", BIST_FAIL_o, BUSY_o);
    end
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      tick();
      if (DONE_o) done = 1;
    end
    checks++;
    if (!done || BIST_FAIL_o !== 1'b0) begin
      errors++;
      $display("FAIL bist_rerun done=%0d fail=%b exp 1 0", done, BIST_FAIL_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    model_mode = 1'b0;
    send_cmd(2'b01, 20'h00401, 10'd0, 10'd7, 18'd0);
    tick();
    PL_RESET_i = 1'b1;
    tick();
    PL_RESET_i = 1'b0;
    checks++;
    if ({PL_ENA_o, PL_WEN_o, PL_REN_o, PL_INIT_o} !== 4'b0 || RDATA_VALID_o !== 1'b0 ||
        RDATA_o !== 18'd0 || DONE_o !== 1'b0 || BUSY_o !== 1'b0 || ERR_o !== 1'b0 ||
        PL_ADDR_o !== 32'd0 || PL_DATA_o !== 18'd0 || CMD_READY_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid strobes=%b rv=%b done=%b busy=%b addr=%h rdy=%b exp 0 0 0 0 0 1",
               {PL_ENA_o, PL_WEN_o, PL_REN_o, PL_INIT_o}, RDATA_VALID_o, DONE_o, BUSY_o,
               PL_ADDR_o, CMD_READY_o);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (RDATA_VALID_o || DONE_o || PL_REN_o) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_quiet got activity after abort exp none");
    end
    send_cmd(2'b00, 20'h00001, 10'd5, 10'd0, 18'd0);
    WDATA_VALID_i = 1'b1; WDATA_i = 18'h3FFFF;
    tick();
    WDATA_VALID_i = 1'b0;
    checks++;
    if (PL_WEN_o !== 1'b1 || PL_ADDR_o !== {20'h00001, 2'b00, 10'd5} ||
        PL_DATA_o !== 18'h3FFFF || DONE_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_newcmd wen=%b addr=%h data=%h done=%b exp 1 00001005 3ffff 1",
               PL_WEN_o, PL_ADDR_o, PL_DATA_o, DONE_o);
    end
    tick();
  endtask

  initial begin
    PL_RESET_i = 1'b1; CMD_VALID_i = 1'b0; CMD_OP_i = 2'b00; CMD_ID_i = '0;
    CMD_ADDR_i = '0; CMD_LEN_i = '0; CMD_PAT_i = '0;
    WDATA_VALID_i = 1'b0; WDATA_i = '0; PL_DATA_IN_i = '0;
    test_reset();
    test_write();
    test_read();
    test_illegal();
    test_bist_pass();
    test_bist_fail();
    test_bist_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
